spi_cmd_sequencer: RTL and testbench
====================================

Name: spi_cmd_sequencer

Overview:
Command queue and sequencer that sits directly upstream of spi_master. It buffers register read/write commands in a small FIFO and launches them one at a time through spi_master's start/read/addr/data inputs. It tracks completion from the chip-select line, returns readback bytes with a valid strobe, and flags transactions that never complete.

Parameters:
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries (default 8)
GAP_CYC, 4, idle clk cycles enforced between consecutive transactions (min 1)
TOUT_CYC, 2048, max clk cycles allowed from launch to transaction end; counter width 12 bits

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept (= not full)
cmd_read  in  1  1 = read, 0 = write
cmd_addr  in  7  register address
cmd_data  in  8  write data (ignored for reads)
spi_start  out  1  one-cycle launch pulse to spi_master
spi_read  out  1  to spi_master spi_read
spi_addr  out  7  to spi_master spi_addr
spi_data  out  8  to spi_master spi_data
cs  in  1  spi_master chip select, active-low, same clk domain
spi_rdbk  in  8  spi_master readback byte
rdbk_valid  out  1  one-cycle pulse: readback available
rdbk_addr  out  7  address of completed read
rdbk_data  out  8  captured readback byte
busy  out  1  high when FIFO non-empty or FSM not IDLE
fifo_level  out  FIFO_AW+1  current FIFO occupancy
timeout_err  out  1  sticky: a transaction timed out
err_clr  in  1  clears timeout_err

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. FIFO is emptied, FSM goes to IDLE, and counters clear. Reset mid-transaction abandons it with no rdbk_valid.
- FIFO: 16-bit entries {read, addr, data}. Push on cmd_valid & cmd_ready. cmd_ready is derived from registered full only, so no push occurs while full even if a pop happens in the same cycle. A simultaneous push and pop when non-full and non-empty leaves the level unchanged. Pointers wrap modulo depth.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the spi_read/spi_addr/spi_data registers and go to LAUNCH.
  - LAUNCH: spi_start=1 for exactly this one cycle; clear the timeout counter; go to WAIT_LO.
  - WAIT_LO: wait for cs=0, then go to WAIT_HI.
  - WAIT_HI: wait for cs=1. Then go to GAP, and if the command was a read, capture spi_rdbk into rdbk_data and the addr into rdbk_addr, and pulse rdbk_valid on the next cycle.
  - GAP: count GAP_CYC cycles, then go to IDLE.
- Latency: the spi_start pulse is asserted 2 cycles after a push into an empty FIFO while in IDLE.
- spi_read/spi_addr/spi_data are held stable from the pop until the FSM next leaves IDLE; they change only on a pop.
- Timeout:
  - The counter increments every cycle in WAIT_LO/WAIT_HI.
  - On reaching TOUT_CYC: set timeout_err, drop the command with no rdbk_valid, and go to GAP.
  - timeout_err is cleared only by err_clr or rst; err_clr and a new timeout in the same cycle leaves it set.
- A cs glitch low→high within WAIT_LO/WAIT_HI follows the transitions above; no filtering.
- Write transactions never pulse rdbk_valid.
- busy is combinational from the FSM state and FIFO empty flag.

Test Plan:
- Single write: push {0,7'h04,8'h21} into idle block → one spi_start pulse 2 cycles later; spi_addr=7'h04, spi_data=8'h21, spi_read=0; busy drops GAP_CYC+1 cycles after cs rises; no rdbk_valid.
- Read: push {1,7'h10,x}; model drives cs low for 200 cycles, then spi_rdbk=8'hA5 and cs high → exactly one rdbk_valid with rdbk_addr=7'h10, rdbk_data=8'hA5.
- Fill/overflow: push 9 commands back-to-back while cs stays high and no launch completes → cmd_ready=0 at fifo_level=8; the 9th command is not accepted; all 8 later issue in order with correct addr/data.
- Simultaneous push/pop at level 3 → level stays 3; order is preserved.
- Timeout: push a command with cs held high forever → timeout_err rises exactly TOUT_CYC cycles after WAIT_LO entry; the next queued command still launches; err_clr pulse clears the flag.
- Reset mid-WAIT_HI with 2 commands queued → all outputs at reset values, fifo_level=0, no spi_start afterwards.

Source files
------------

// File: rtl/spi_cmd_sequencer_if.sv
// Command, SPI-launch and readback signals shared between spi_cmd_sequencer and its requester.
interface spi_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_read;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       spi_start;
    logic       spi_read;
    logic [6:0] spi_addr;
    logic [7:0] spi_data;
    logic       cs;
    logic [7:0] spi_rdbk;
    logic       rdbk_valid;
    logic [6:0] rdbk_addr;
    logic [7:0] rdbk_data;

    // slave is the sequencer side; master is the command source / SPI environment
    modport slave (
        input  cmd_valid, cmd_read, cmd_addr, cmd_data, cs, spi_rdbk,
        output cmd_ready, spi_start, spi_read, spi_addr, spi_data,
        output rdbk_valid, rdbk_addr, rdbk_data
    );

    modport master (
        output cmd_valid, cmd_read, cmd_addr, cmd_data, cs, spi_rdbk,
        input  cmd_ready, spi_start, spi_read, spi_addr, spi_data,
        input  rdbk_valid, rdbk_addr, rdbk_data
    );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// Buffers register read/write commands and launches them one at a time into spi_master,
// tracking completion from chip select and returning readback bytes.
module spi_cmd_sequencer #(
    parameter int FIFO_AW  = 3,
    parameter int GAP_CYC  = 4,
    parameter int TOUT_CYC = 2048
) (
    input  logic               clk,
    input  logic               rst,
    spi_cmd_sequencer_if.slave bus,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               timeout_err,
    input  logic               err_clr
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int LVL_W = FIFO_AW + 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);
    localparam logic [11:0]      TOUT_LAST = 12'(TOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_LO, WAIT_HI, GAP} state_t;

    state_t           state, state_nxt;
    logic [15:0]      mem [DEPTH];
    logic [LVL_W-1:0] wr_ptr, rd_ptr;
    logic             fifo_empty, fifo_full;
    logic             push, pop;
    logic             spi_read_q;
    logic [6:0]       spi_addr_q;
    logic [7:0]       spi_data_q;
    logic [11:0]      tout_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             rdbk_load, tout_hit, start;
    logic             rdbk_valid_q;
    logic [6:0]       rdbk_addr_q;
    logic [7:0]       rdbk_data_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (fifo_level == LVL_W'(DEPTH));
    assign push       = bus.cmd_valid & ~fifo_full;

    assign bus.cmd_ready  = ~fifo_full;
    assign bus.spi_start  = start;
    assign bus.spi_read   = spi_read_q;
    assign bus.spi_addr   = spi_addr_q;
    assign bus.spi_data   = spi_data_q;
    assign bus.rdbk_valid = rdbk_valid_q;
    assign bus.rdbk_addr  = rdbk_addr_q;
    assign bus.rdbk_data  = rdbk_data_q;
    assign busy           = (state != IDLE) | ~fifo_empty;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[FIFO_AW-1:0]] <= {bus.cmd_read, bus.cmd_addr, bus.cmd_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        start     = 1'b0;
        rdbk_load = 1'b0;
        tout_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                start     = 1'b1;
                state_nxt = WAIT_LO;
            end
            WAIT_LO: begin
                if (!bus.cs) begin
                    state_nxt = WAIT_HI;
                end else if (tout_cnt == TOUT_LAST) begin
                    tout_hit  = 1'b1;
                    state_nxt = GAP;
                end
            end
            WAIT_HI: begin
                // A cs edge landing on the timeout cycle counts as completion.
                if (bus.cs) begin
                    rdbk_load = spi_read_q;
                    state_nxt = GAP;
                end else if (tout_cnt == TOUT_LAST) begin
                    tout_hit  = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            spi_read_q   <= 1'b0;
            spi_addr_q   <= '0;
            spi_data_q   <= '0;
            tout_cnt     <= '0;
            gap_cnt      <= '0;
            rdbk_valid_q <= 1'b0;
            rdbk_addr_q  <= '0;
            rdbk_data_q  <= '0;
            timeout_err  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                {spi_read_q, spi_addr_q, spi_data_q} <= mem[rd_ptr[FIFO_AW-1:0]];
            end
            if (state == LAUNCH)
                tout_cnt <= '0;
            else if (state == WAIT_LO || state == WAIT_HI)
                tout_cnt <= tout_cnt + 1'b1;
            gap_cnt      <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            rdbk_valid_q <= rdbk_load;
            if (rdbk_load) begin
                rdbk_addr_q <= spi_addr_q;
                rdbk_data_q <= bus.spi_rdbk;
            end
            // A new timeout wins over a simultaneous clear.
            if (tout_hit)
                timeout_err <= 1'b1;
            else if (err_clr)
                timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: launches and readbacks are checked in order against queues.
module tb_spi_cmd_sequencer;
    localparam int FIFO_AW  = 3;
    localparam int GAP_CYC  = 4;
    localparam int TOUT_CYC = 2048;
    localparam logic [39:0] RST_OUTS = {1'b1, 39'd0};

    logic             clk = 1'b0;
    logic             rst;
    logic             err_clr;
    logic             busy;
    logic [FIFO_AW:0] fifo_level;
    logic             timeout_err;

    spi_cmd_sequencer_if bus();

    spi_cmd_sequencer #(
        .FIFO_AW(FIFO_AW), .GAP_CYC(GAP_CYC), .TOUT_CYC(TOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy),
        .fifo_level(fifo_level), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_start = 0;
    int n_rdbk = 0;
    logic [15:0] exp_launch[$];
    logic [14:0] exp_rdbk[$];
    logic [15:0] mon_e;
    logic [14:0] mon_r;

    function automatic logic [39:0] outs();
        return {bus.cmd_ready, bus.spi_start, bus.spi_read, bus.spi_addr, bus.spi_data,
                bus.rdbk_valid, bus.rdbk_addr, bus.rdbk_data, busy, fifo_level, timeout_err};
    endfunction

    // Every launch and every readback strobe is matched against the expected queues.
    always @(negedge clk) begin
        if (!rst && bus.spi_start === 1'b1) begin
            n_start++;
            total++;
            if (exp_launch.size() == 0) begin
                bad++;
                $display("FAIL launch_unexpected got=%h want=none", {bus.spi_read, bus.spi_addr, bus.spi_data});
            end else begin
                mon_e = exp_launch.pop_front();
                if ({bus.spi_read, bus.spi_addr, bus.spi_data} !== mon_e) begin
                    bad++;
                    $display("FAIL launch_cmd got=%h want=%h", {bus.spi_read, bus.spi_addr, bus.spi_data}, mon_e);
                end
            end
        end
        if (!rst && bus.rdbk_valid === 1'b1) begin
            n_rdbk++;
            total++;
            if (exp_rdbk.size() == 0) begin
                bad++;
                $display("FAIL rdbk_unexpected got=%h want=none", {bus.rdbk_addr, bus.rdbk_data});
            end else begin
                mon_r = exp_rdbk.pop_front();
                if ({bus.rdbk_addr, bus.rdbk_data} !== mon_r) begin
                    bad++;
                    $display("FAIL rdbk_value got=%h want=%h", {bus.rdbk_addr, bus.rdbk_data}, mon_r);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push1(input bit rd, input logic [6:0] a, input logic [7:0] d, input bit exp_acc);
        bus.cmd_valid = 1'b1;
        bus.cmd_read  = rd;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        if (exp_acc) exp_launch.push_back({rd, a, d});
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.spi_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Play spi_master: chip select low for nlow cycles, then present rb and release.
    task automatic complete(input int nlow, input logic [7:0] rb);
        bus.cs       = 1'b0;
        bus.spi_rdbk = 8'h5A;
        repeat (nlow) @(negedge clk);
        bus.spi_rdbk = rb;
        bus.cs       = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        total++;
        if (outs() !== RST_OUTS) begin bad++; $display("FAIL reset_hold got=%h want=%h", outs(), RST_OUTS); end
        rst = 1'b0;
        tick(2);
        total++;
        if (outs() !== RST_OUTS) begin bad++; $display("FAIL reset_release got=%h want=%h", outs(), RST_OUTS); end
    endtask

    task automatic test_single_write();
        int s_rd;
        bit ok;
        s_rd = n_rdbk;
        push1(1'b0, 7'h04, 8'h21, 1'b1);
        total++;
        if (bus.spi_start !== 1'b0) begin bad++; $display("FAIL wr_latency_early got=%b want=0", bus.spi_start); end
        total++;
        if (fifo_level !== 4'd1) begin bad++; $display("FAIL wr_level got=%0d want=1", fifo_level); end
        @(negedge clk);
        total++;
        if (bus.spi_start !== 1'b1) begin bad++; $display("FAIL wr_latency got=%b want=1", bus.spi_start); end
        complete(10, 8'h00);
        tick(GAP_CYC);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy_gap got=%b want=1", busy); end
        tick(1);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_drop got=%b want=0", busy); end
        total++;
        if ({bus.spi_read, bus.spi_addr, bus.spi_data} !== {1'b0, 7'h04, 8'h21}) begin
            bad++;
            $display("FAIL wr_hold got=%h want=%h", {bus.spi_read, bus.spi_addr, bus.spi_data}, {1'b0, 7'h04, 8'h21});
        end
        wait_idle(ok);
        total++;
        if (n_rdbk !== s_rd) begin bad++; $display("FAIL wr_no_rdbk got=%0d want=%0d", n_rdbk, s_rd); end
    endtask

    task automatic test_read();
        int s_rd;
        bit ok;
        s_rd = n_rdbk;
        exp_rdbk.push_back({7'h10, 8'hA5});
        push1(1'b1, 7'h10, 8'h00, 1'b1);
        wait_start(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rd_start got=none want=launch"); end
        complete(200, 8'hA5);
        @(negedge clk);
        bus.spi_rdbk = 8'h00;
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rd_idle got=busy want=idle"); end
        total++;
        if (n_rdbk !== s_rd + 1) begin bad++; $display("FAIL rd_count got=%0d want=%0d", n_rdbk, s_rd + 1); end
        total++;
        if ({bus.rdbk_addr, bus.rdbk_data} !== {7'h10, 8'hA5}) begin
            bad++;
            $display("FAIL rd_hold got=%h want=%h", {bus.rdbk_addr, bus.rdbk_data}, {7'h10, 8'hA5});
        end
    endtask

    task automatic test_fill();
        bit ok;
        push1(1'b0, 7'h01, 8'h11, 1'b1);
        wait_start(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL fill_a_start got=none want=launch"); end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (bus.cmd_ready !== 1'(i < 8)) begin
                bad++;
                $display("FAIL fill_ready i=%0d got=%b want=%b", i, bus.cmd_ready, 1'(i < 8));
            end
            bus.cmd_valid = 1'b1;
            bus.cmd_read  = 1'b0;
            bus.cmd_addr  = 7'(7'h40 + i);
            bus.cmd_data  = 8'(8'h80 + i);
            if (i < 8) exp_launch.push_back({1'b0, 7'(7'h40 + i), 8'(8'h80 + i)});
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        total++;
        if (fifo_level !== 4'd8) begin bad++; $display("FAIL fill_level got=%0d want=8", fifo_level); end
        total++;
        if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL fill_full got=%b want=0", bus.cmd_ready); end
        complete(3, 8'h00);
        for (int i = 0; i < 8; i++) begin
            wait_start(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL fill_start i=%0d got=none want=launch", i); end
            complete(3, 8'h00);
        end
        wait_idle(ok);
        total++;
        if (exp_launch.size() != 0) begin bad++; $display("FAIL fill_drained got=%0d want=0", exp_launch.size()); end
    endtask

    task automatic test_simul_pushpop();
        bit ok;
        push1(1'b0, 7'h02, 8'h22, 1'b1);
        wait_start(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL pp_b_start got=none want=launch"); end
        for (int i = 0; i < 3; i++) push1(1'b0, 7'(7'h50 + i), 8'(8'h90 + i), 1'b1);
        total++;
        if (fifo_level !== 4'd3) begin bad++; $display("FAIL pp_level_pre got=%0d want=3", fifo_level); end
        complete(3, 8'h00);
        tick(GAP_CYC + 1);
        // The FSM is in IDLE here, so this push meets the pop on the same edge.
        bus.cmd_valid = 1'b1;
        bus.cmd_read  = 1'b0;
        bus.cmd_addr  = 7'h5F;
        bus.cmd_data  = 8'h9F;
        exp_launch.push_back({1'b0, 7'h5F, 8'h9F});
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        total++;
        if (fifo_level !== 4'd3) begin bad++; $display("FAIL pp_level_hold got=%0d want=3", fifo_level); end
        total++;
        if (bus.spi_start !== 1'b1) begin bad++; $display("FAIL pp_launch got=%b want=1", bus.spi_start); end
        complete(3, 8'h00);
        for (int i = 0; i < 3; i++) begin
            wait_start(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL pp_start i=%0d got=none want=launch", i); end
            complete(3, 8'h00);
        end
        wait_idle(ok);
        total++;
        if (exp_launch.size() != 0) begin bad++; $display("FAIL pp_order got=%0d want=0", exp_launch.size()); end
    endtask

    task automatic test_timeout();
        int s_rd;
        bit ok;
        s_rd = n_rdbk;
        push1(1'b1, 7'h22, 8'h00, 1'b1);
        wait_start(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL tout_start got=none want=launch"); end
        bus.cmd_valid = 1'b1;
        bus.cmd_read  = 1'b0;
        bus.cmd_addr  = 7'h33;
        bus.cmd_data  = 8'h44;
        exp_launch.push_back({1'b0, 7'h33, 8'h44});
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        tick(TOUT_CYC - 1);
        total++;
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL tout_early got=%b want=0", timeout_err); end
        tick(1);
        total++;
        if (timeout_err !== 1'b1) begin bad++; $display("FAIL tout_rise got=%b want=1", timeout_err); end
        wait_start(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL tout_next got=none want=launch"); end
        complete(3, 8'h00);
        wait_idle(ok);
        total++;
        if (timeout_err !== 1'b1) begin bad++; $display("FAIL tout_sticky got=%b want=1", timeout_err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++;
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL tout_clear got=%b want=0", timeout_err); end
        total++;
        if (n_rdbk !== s_rd) begin bad++; $display("FAIL tout_no_rdbk got=%0d want=%0d", n_rdbk, s_rd); end
    endtask

    task automatic test_reset_mid();
        int s_rd;
        int s_st;
        bit ok;
        s_rd = n_rdbk;
        push1(1'b1, 7'h66, 8'h00, 1'b1);
        wait_start(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rm_start got=none want=launch"); end
        bus.cs = 1'b0;
        tick(5);
        push1(1'b0, 7'h70, 8'h01, 1'b0);
        push1(1'b0, 7'h71, 8'h02, 1'b0);
        total++;
        if (fifo_level !== 4'd2) begin bad++; $display("FAIL rm_level got=%0d want=2", fifo_level); end
        rst = 1'b1;
        #1;
        total++;
        if (outs() !== RST_OUTS) begin bad++; $display("FAIL rm_reset_outs got=%h want=%h", outs(), RST_OUTS); end
        bus.cs = 1'b1;
        tick(2);
        rst = 1'b0;
        s_st = n_start;
        tick(50);
        total++;
        if (n_start !== s_st) begin bad++; $display("FAIL rm_no_start got=%0d want=%0d", n_start, s_st); end
        total++;
        if (outs() !== RST_OUTS) begin bad++; $display("FAIL rm_idle_outs got=%h want=%h", outs(), RST_OUTS); end
        total++;
        if (n_rdbk !== s_rd) begin bad++; $display("FAIL rm_no_rdbk got=%0d want=%0d", n_rdbk, s_rd); end
    endtask

    initial begin
        rst           = 1'b1;
        err_clr       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_read  = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.cs        = 1'b1;
        bus.spi_rdbk  = '0;
        @(negedge clk);
        test_reset();
        test_single_write();
        test_read();
        test_fill();
        test_simul_pushpop();
        test_timeout();
        test_reset_mid();
        total++;
        if (exp_launch.size() != 0) begin bad++; $display("FAIL sb_launch_left got=%0d want=0", exp_launch.size()); end
        total++;
        if (exp_rdbk.size() != 0) begin bad++; $display("FAIL sb_rdbk_left got=%0d want=0", exp_rdbk.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
